// File: rtl/template_rom_rr_arbiter_if.sv
// Requester/ROM bundle for template_rom_rr_arbiter. The master side is the requesters plus the ROM;
// the slave side is the arbiter.
interface template_rom_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [ADDR_WIDTH-1:0]         rom_addr;
  logic [DATA_WIDTH-1:0]         rom_rd_data;

  modport master (
    output req_valid, req_addr, req_lock, rom_rd_data,
    input  req_ready, rsp_valid, rsp_data, rom_addr
  );

  modport slave (
    input  req_valid, req_addr, req_lock, rom_rd_data,
    output req_ready, rsp_valid, rsp_data, rom_addr
  );
endinterface

// File: rtl/template_rom_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous-read template ROM between NUM_REQ requesters.
// Define TEMPLATE_ROM_ARB_LOCK_EN to compile in the burst-lock FSM (ARB/LOCKED) driven by req_lock.

module template_rom_rr_lane #(
  parameter int ADDR_WIDTH = 11,
  parameter int IDX_W      = 2,
  parameter int LANE       = 0
) (
  input  logic                  gnt,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  tag_vld,
  input  logic [IDX_W-1:0]      tag_id,
  output logic [ADDR_WIDTH-1:0] addr_sel,
  output logic                  rsp_vld
);
  // Masked address lets the top OR-reduce a one-hot selection without an index mux
  assign addr_sel = gnt ? addr : '0;
  assign rsp_vld  = tag_vld && (tag_id == IDX_W'(LANE));
endmodule

module template_rom_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  template_rom_rr_arbiter_if.slave bus
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = RD_LATENCY;

  logic [IDX_W-1:0]                 last_gnt;
  logic [NUM_REQ-1:0]               rr_gnt;
  logic [IDX_W-1:0]                 rr_idx;
  logic                             rr_any;
  logic [NUM_REQ-1:0]               gnt;
  logic [IDX_W-1:0]                 gnt_idx;
  logic                             gnt_any;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] lane_addr;
  logic [ADDR_WIDTH-1:0]            sel_addr;
  logic [ADDR_WIDTH-1:0]            rom_addr_q;
  logic [NUM_REQ-1:0]               rsp_vld;
  logic [STAGES:0]                  vld_pipe;
  logic [STAGES:0][IDX_W-1:0]       id_pipe;

  // Search last_gnt+1, last_gnt+2, ... and take the first valid requester
  always_comb begin
    rr_gnt = '0;
    rr_idx = '0;
    rr_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [IDX_W-1:0] j;
      j = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
      if (!rr_any && bus.req_valid[j]) begin
        rr_any    = 1'b1;
        rr_gnt[j] = 1'b1;
        rr_idx    = j;
      end
    end
  end

`ifdef TEMPLATE_ROM_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} lock_state_e;
  lock_state_e      state;
  logic [IDX_W-1:0] owner;
  logic             hold;

  // Lock release takes effect combinationally, so arbitration resumes in the release cycle
  assign hold = (state == LOCKED) && bus.req_lock[owner];

  always_comb begin
    gnt     = rr_gnt;
    gnt_idx = rr_idx;
    gnt_any = rr_any;
    if (hold) begin
      gnt        = '0;
      gnt[owner] = bus.req_valid[owner];
      gnt_idx    = owner;
      gnt_any    = bus.req_valid[owner];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
      owner <= '0;
    end else if (!hold) begin
      if (gnt_any && bus.req_lock[gnt_idx]) begin
        state <= LOCKED;
        owner <= gnt_idx;
      end else begin
        state <= ARB;
      end
    end
  end
`else
  logic unused_req_lock;
  assign unused_req_lock = ^bus.req_lock;
  assign gnt     = rr_gnt;
  assign gnt_idx = rr_idx;
  assign gnt_any = rr_any;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    template_rom_rr_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .IDX_W      (IDX_W),
      .LANE       (i)
    ) u_lane (
      .gnt      (gnt[i]),
      .addr     (bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .tag_vld  (vld_pipe[STAGES]),
      .tag_id   (id_pipe[STAGES]),
      .addr_sel (lane_addr[i]),
      .rsp_vld  (rsp_vld[i])
    );
  end

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) sel_addr = sel_addr | lane_addr[i];
  end

  // Tag stage 0 lines up with rom_addr; stage RD_LATENCY lines up with rom_rd_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q <= '0;
      last_gnt   <= IDX_W'(NUM_REQ - 1);
      vld_pipe   <= '0;
      id_pipe    <= '0;
    end else begin
      if (gnt_any) begin
        rom_addr_q <= sel_addr;
        last_gnt   <= gnt_idx;
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], gnt_any};
      id_pipe  <= {id_pipe[STAGES-1:0], gnt_idx};
    end
  end

  assign bus.req_ready = gnt & {NUM_REQ{~rst}};
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_data  = (|rsp_vld) ? bus.rom_rd_data : '0;
endmodule

// File: tb/tb_template_rom_rr_arbiter.sv
// Directed vector bench for template_rom_rr_arbiter: RD_LATENCY=1 main instance plus an RD_LATENCY=2 instance.
module tb_template_rom_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  template_rom_rr_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(11), .DATA_WIDTH(8)) bus ();
  template_rom_rr_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(11), .DATA_WIDTH(8)) bus2 ();

  template_rom_rr_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(11), .DATA_WIDTH(8), .RD_LATENCY(1)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  template_rom_rr_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(11), .DATA_WIDTH(8), .RD_LATENCY(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  // ROM models: mem[a] = a[7:0]^8'h5A, except mem[5]=8'hA7
  logic [7:0] mem [2048];
  logic [7:0] rom2_stage;
  always @(posedge clk) bus.rom_rd_data <= mem[bus.rom_addr];
  always @(posedge clk) begin
    rom2_stage       <= mem[bus2.rom_addr];
    bus2.rom_rd_data <= rom2_stage;
  end

  typedef struct {
    logic [3:0]       valid;
    logic [3:0]       lock;
    logic [3:0][10:0] addr;
    logic [3:0]       exp_ready;
    logic [3:0]       exp_rsp;
    logic [7:0]       exp_data;
    logic [10:0]      exp_rom;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] lock,
                              input logic [10:0] a0, input logic [10:0] a1,
                              input logic [10:0] a2, input logic [10:0] a3,
                              input logic [3:0] rdy, input logic [3:0] rsp,
                              input logic [7:0] d, input logic [10:0] rom);
    vec_t v;
    v.valid = valid; v.lock = lock; v.addr = {a3, a2, a1, a0};
    v.exp_ready = rdy; v.exp_rsp = rsp; v.exp_data = d; v.exp_rom = rom;
    return v;
  endfunction

  task automatic apply(input vec_t t, input string tag);
    bus.req_valid = t.valid;
    bus.req_lock  = t.lock;
    bus.req_addr  = t.addr;
    #1;
    chk($sformatf("%s ready", tag), 32'(bus.req_ready), 32'(t.exp_ready));
    chk($sformatf("%s rsp_valid", tag), 32'(bus.rsp_valid), 32'(t.exp_rsp));
    chk($sformatf("%s rom_addr", tag), 32'(bus.rom_addr), 32'(t.exp_rom));
    if (t.exp_rsp != 4'b0000)
      chk($sformatf("%s rsp_data", tag), 32'(bus.rsp_data), 32'(t.exp_data));
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [20];
  vec_t ltbl [5];

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'(a) ^ 8'h5A;
    mem[5] = 8'hA7;

    // contention, drain, single requester, rotation after a gap
    tbl[0]  = mk(4'b1111, 4'b0, 11'h10, 11'h11, 11'h12, 11'h13, 4'b0001, 4'b0000, 8'h00, 11'h000);
    tbl[1]  = mk(4'b1111, 4'b0, 11'h10, 11'h11, 11'h12, 11'h13, 4'b0010, 4'b0000, 8'h00, 11'h010);
    tbl[2]  = mk(4'b1111, 4'b0, 11'h10, 11'h11, 11'h12, 11'h13, 4'b0100, 4'b0001, 8'h4A, 11'h011);
    tbl[3]  = mk(4'b1111, 4'b0, 11'h10, 11'h11, 11'h12, 11'h13, 4'b1000, 4'b0010, 8'h4B, 11'h012);
    tbl[4]  = mk(4'b1111, 4'b0, 11'h10, 11'h11, 11'h12, 11'h13, 4'b0001, 4'b0100, 8'h48, 11'h013);
    tbl[5]  = mk(4'b1111, 4'b0, 11'h10, 11'h11, 11'h12, 11'h13, 4'b0010, 4'b1000, 8'h49, 11'h010);
    tbl[6]  = mk(4'b1111, 4'b0, 11'h10, 11'h11, 11'h12, 11'h13, 4'b0100, 4'b0001, 8'h4A, 11'h011);
    tbl[7]  = mk(4'b1111, 4'b0, 11'h10, 11'h11, 11'h12, 11'h13, 4'b1000, 4'b0010, 8'h4B, 11'h012);
    tbl[8]  = mk(4'b0000, 4'b0, 11'h00, 11'h00, 11'h00, 11'h00, 4'b0000, 4'b0100, 8'h48, 11'h013);
    tbl[9]  = mk(4'b0000, 4'b0, 11'h00, 11'h00, 11'h00, 11'h00, 4'b0000, 4'b1000, 8'h49, 11'h013);
    tbl[10] = mk(4'b0100, 4'b0, 11'h00, 11'h00, 11'h05, 11'h00, 4'b0100, 4'b0000, 8'h00, 11'h013);
    tbl[11] = mk(4'b0000, 4'b0, 11'h00, 11'h00, 11'h00, 11'h00, 4'b0000, 4'b0000, 8'h00, 11'h005);
    tbl[12] = mk(4'b0000, 4'b0, 11'h00, 11'h00, 11'h00, 11'h00, 4'b0000, 4'b0100, 8'hA7, 11'h005);
    tbl[13] = mk(4'b0010, 4'b0, 11'h00, 11'h20, 11'h00, 11'h00, 4'b0010, 4'b0000, 8'h00, 11'h005);
    tbl[14] = mk(4'b0000, 4'b0, 11'h00, 11'h00, 11'h00, 11'h00, 4'b0000, 4'b0000, 8'h00, 11'h020);
    tbl[15] = mk(4'b1001, 4'b0, 11'h30, 11'h00, 11'h00, 11'h33, 4'b1000, 4'b0010, 8'h7A, 11'h020);
    tbl[16] = mk(4'b0001, 4'b0, 11'h30, 11'h00, 11'h00, 11'h00, 4'b0001, 4'b0000, 8'h00, 11'h033);
    tbl[17] = mk(4'b0000, 4'b0, 11'h00, 11'h00, 11'h00, 11'h00, 4'b0000, 4'b1000, 8'h69, 11'h030);
    tbl[18] = mk(4'b0000, 4'b0, 11'h00, 11'h00, 11'h00, 11'h00, 4'b0000, 4'b0001, 8'h6A, 11'h030);
    tbl[19] = mk(4'b0000, 4'b0, 11'h00, 11'h00, 11'h00, 11'h00, 4'b0000, 4'b0000, 8'h00, 11'h030);

    // burst lock by requester 1 while requester 0 waits (last_gnt=3 after reset)
    ltbl[0] = mk(4'b0010, 4'b0010, 11'h000, 11'h100, 11'h0, 11'h0, 4'b0010, 4'b0000, 8'h00, 11'h000);
    ltbl[1] = mk(4'b0011, 4'b0010, 11'h050, 11'h101, 11'h0, 11'h0, 4'b0010, 4'b0000, 8'h00, 11'h100);
    ltbl[2] = mk(4'b0011, 4'b0010, 11'h050, 11'h102, 11'h0, 11'h0, 4'b0010, 4'b0010, 8'h5A, 11'h101);
    ltbl[3] = mk(4'b0001, 4'b0010, 11'h050, 11'h000, 11'h0, 11'h0, 4'b0000, 4'b0010, 8'h5B, 11'h102);
    ltbl[4] = mk(4'b0001, 4'b0000, 11'h050, 11'h000, 11'h0, 11'h0, 4'b0001, 4'b0010, 8'h58, 11'h102);

    bus.req_valid = '0;  bus.req_lock = '0;  bus.req_addr = '0;
    bus2.req_valid = '0; bus2.req_lock = '0; bus2.req_addr = '0;

    // reset state
    step();
    chk("reset ready", 32'(bus.req_ready), 32'h0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset rsp_data", 32'(bus.rsp_data), 32'h0);
    chk("reset rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("reset rsp_valid lat2", 32'(bus2.rsp_valid), 32'h0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // reset mid-flight: grants to 2 then 3, reset lands before the first response
    bus.req_valid = 4'b0100; bus.req_addr = {11'h0, 11'h040, 11'h0, 11'h0};
    #1;
    chk("midrst grant0 ready", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid = 4'b1000; bus.req_addr = {11'h041, 11'h0, 11'h0, 11'h0};
    #1;
    chk("midrst grant1 ready", 32'(bus.req_ready), 32'b1000);
    #2;
    rst = 1'b1;
    step();
    bus.req_valid = '0;
    #1;
    chk("midrst rsp_valid in reset", 32'(bus.rsp_valid), 32'h0);
    chk("midrst rom_addr in reset", 32'(bus.rom_addr), 32'h0);
    chk("midrst ready in reset", 32'(bus.req_ready), 32'h0);
    step();
    rst = 1'b0;
    bus.req_valid = 4'b1010; bus.req_addr = {11'h053, 11'h0, 11'h050, 11'h0};
    #1;
    chk("postrst first ready", 32'(bus.req_ready), 32'b0010);
    chk("postrst rsp_valid a", 32'(bus.rsp_valid), 32'h0);
    step();
    #1;
    chk("postrst second ready", 32'(bus.req_ready), 32'b1000);
    chk("postrst rsp_valid b", 32'(bus.rsp_valid), 32'h0);
    chk("postrst rom_addr", 32'(bus.rom_addr), 32'h050);
    step();
    bus.req_valid = '0;
    #1;
    chk("postrst rsp1 valid", 32'(bus.rsp_valid), 32'b0010);
    chk("postrst rsp1 data", 32'(bus.rsp_data), 32'h0A);
    step();
    #1;
    chk("postrst rsp3 valid", 32'(bus.rsp_valid), 32'b1000);
    chk("postrst rsp3 data", 32'(bus.rsp_data), 32'h09);
    step();

    // RD_LATENCY=2 instance: last_gnt=3 since the reset above
    bus2.req_valid = 4'b0001; bus2.req_addr = {11'h0, 11'h0, 11'h0, 11'h005};
    #1;
    chk("lat2 ready", 32'(bus2.req_ready), 32'b0001);
    chk("lat2 rsp c0", 32'(bus2.rsp_valid), 32'h0);
    step();
    bus2.req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("lat2 rsp c%0d", c), 32'(bus2.rsp_valid), (c == 3) ? 32'b0001 : 32'h0);
      if (c == 3) chk("lat2 rsp_data", 32'(bus2.rsp_data), 32'hA7);
      step();
    end

`ifdef TEMPLATE_ROM_ARB_LOCK_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) apply(ltbl[i], $sformatf("lock%0d", i));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
